// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: fetch FSM states, widths, NOP encoding and
// the major opcodes consumed by the control decoder.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] OP_IMM = 7'b0010011;

  typedef enum logic [1:0] {
    FETCH_IDLE,
    FETCH_REQ,
    FETCH_WAIT,
    FETCH_HOLD
  } fetch_state_t;

endpackage

// File: rtl/pc_next.sv
// Next-PC select: sequential PC+4, or a redirect target with its low two bits
// cleared (misaligned targets are silently aligned, never faulted).
module pc_next #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] i_pc,
  input  logic            i_branch_taken,
  input  logic [XLEN-1:0] i_branch_target,
  output logic [XLEN-1:0] o_pc_next
);

  logic [XLEN-1:0] w_pc_seq;
  logic [XLEN-1:0] w_pc_target;

  assign w_pc_seq    = i_pc + XLEN'(4);
  assign w_pc_target = {i_branch_target[XLEN-1:2], 2'b00};
  assign o_pc_next   = i_branch_taken ? w_pc_target : w_pc_seq;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one imem request at a time and
// holds the returned word for decode until it is accepted.
module fetch_unit #(
  parameter int              XLEN     = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [31:0]     instr,
  output logic [6:0]      opcode,
  output logic [XLEN-1:0] pc_out,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  output logic [31:0]     retired_count
);

  import riscv_pkg::*;

  fetch_state_t    r_state;
  fetch_state_t    w_state_next;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc_next;
  logic [31:0]     r_instr;
  logic [31:0]     r_retired;
  logic            w_accept;
  logic            w_capture;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= FETCH_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      FETCH_IDLE: w_state_next = FETCH_REQ;
      FETCH_REQ:  if (imem_req_ready) w_state_next = FETCH_WAIT;
      FETCH_WAIT: if (imem_rsp_valid) w_state_next = FETCH_HOLD;
      FETCH_HOLD: if (instr_ready)    w_state_next = FETCH_REQ;
      default:    w_state_next = FETCH_IDLE;
    endcase
  end

  // Responses are only meaningful in WAIT; anything else (stale or spurious) is dropped.
  assign w_capture = (r_state == FETCH_WAIT) && imem_rsp_valid;
  assign w_accept  = (r_state == FETCH_HOLD) && instr_ready;

  pc_next #(
    .XLEN(XLEN)
  ) u_pc_next (
    .i_pc           (r_pc),
    .i_branch_taken (branch_taken),
    .i_branch_target(branch_target),
    .o_pc_next      (w_pc_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc      <= RESET_PC;
      r_instr   <= NOP_INSTR;
      r_retired <= '0;
    end else begin
      if (w_capture) begin
        r_instr <= imem_rsp_data;
      end
      if (w_accept) begin
        r_pc      <= w_pc_next;
        r_retired <= r_retired + 32'd1;
      end
    end
  end

  assign imem_req_valid = (r_state == FETCH_REQ);
  assign instr_valid    = (r_state == FETCH_HOLD);
  assign imem_addr      = r_pc;
  assign pc_out         = r_pc;
  assign instr          = r_instr;
  assign opcode         = r_instr[6:0];
  assign retired_count  = r_retired;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized
// memory/downstream run checked against a transaction-level fetch model.
module tb_fetch_unit;

  localparam int          XL  = 32;
  localparam logic [31:0] RST = 32'h0000_0100;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          imem_req_valid;
  logic          imem_req_ready;
  logic [XL-1:0] imem_addr;
  logic          imem_rsp_valid;
  logic [31:0]   imem_rsp_data;
  logic          instr_valid;
  logic          instr_ready;
  logic [31:0]   instr;
  logic [6:0]    opcode;
  logic [XL-1:0] pc_out;
  logic          branch_taken;
  logic [XL-1:0] branch_target;
  logic [31:0]   retired_count;

  int total = 0;
  int bad   = 0;

  fetch_unit #(
    .XLEN    (XL),
    .RESET_PC(RST)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_addr     (imem_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr         (instr),
    .opcode        (opcode),
    .pc_out        (pc_out),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .retired_count (retired_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    instr_ready    = 1'b0;
    branch_taken   = 1'b0;
    branch_target  = '0;
  endtask

  // Leaves the DUT in its first post-reset cycle (IDLE), sampled 1 ns after the edge.
  task automatic apply_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Runs one full fetch starting in REQ; ends back in REQ.
  task automatic fetch_one(input logic [31:0] data, input logic taken, input logic [XL-1:0] target);
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = data;
    tick();
    imem_rsp_valid = 1'b0;
    instr_ready    = 1'b1;
    branch_taken   = taken;
    branch_target  = target;
    tick();
    instr_ready  = 1'b0;
    branch_taken = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL reset_req_valid got=%b exp=0", imem_req_valid); end
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL reset_instr_valid got=%b exp=0", instr_valid); end
    total++; if (instr !== NOP) begin bad++; $display("FAIL reset_instr got=%h exp=%h", instr, NOP); end
    total++; if (opcode !== 7'h13) begin bad++; $display("FAIL reset_opcode got=%h exp=13", opcode); end
    total++; if (pc_out !== RST) begin bad++; $display("FAIL reset_pc got=%h exp=%h", pc_out, RST); end
    total++; if (retired_count !== 32'd0) begin bad++; $display("FAIL reset_retired got=%0d exp=0", retired_count); end
    tick();
    rst_n = 1'b1;
    total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL idle_req_valid got=%b exp=0", imem_req_valid); end
    tick();
    total++; if (imem_req_valid !== 1'b1 || imem_addr !== RST) begin bad++; $display("FAIL first_req got valid=%b addr=%h exp valid=1 addr=%h", imem_req_valid, imem_addr, RST); end
    $display("reset: first request valid=%b addr=%h", imem_req_valid, imem_addr);
  endtask

  task automatic test_throughput();
    int req_cyc[4];
    logic [XL-1:0] req_addr[4];
    logic [31:0] ret_at_4th;
    int nreq = 0;
    logic last_req = 1'b0;
    apply_reset();
    imem_req_ready = 1'b1;
    instr_ready    = 1'b1;
    imem_rsp_data  = NOP;
    for (int c = 0; c < 40 && nreq < 4; c++) begin
      if (imem_req_valid) begin
        req_cyc[nreq]  = c;
        req_addr[nreq] = imem_addr;
        if (nreq == 3) ret_at_4th = retired_count;
        nreq++;
      end
      imem_rsp_valid = last_req;
      last_req = imem_req_valid;
      if (nreq < 4) tick();
    end
    idle_inputs();
    total++;
    if (nreq != 4) begin
      bad++; $display("FAIL tput_timeout got=%0d requests exp=4", nreq);
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (req_addr[i] !== RST + 32'(4 * i)) begin bad++; $display("FAIL tput_addr%0d got=%h exp=%h", i, req_addr[i], RST + 32'(4 * i)); end
        if (i > 0) begin
          total++;
          if (req_cyc[i] - req_cyc[i-1] != 3) begin bad++; $display("FAIL tput_spacing%0d got=%0d exp=3", i, req_cyc[i] - req_cyc[i-1]); end
        end
        $display("throughput: req %0d addr=%h cycle=%0d", i, req_addr[i], req_cyc[i]);
      end
      total++; if (ret_at_4th !== 32'd3) begin bad++; $display("FAIL tput_retired got=%0d exp=3", ret_at_4th); end
    end
  endtask

  task automatic test_req_stall();
    apply_reset();
    tick();
    for (int i = 0; i < 4; i++) begin
      total++;
      if (imem_req_valid !== 1'b1 || imem_addr !== RST) begin bad++; $display("FAIL stall_hold%0d got valid=%b addr=%h exp valid=1 addr=%h", i, imem_req_valid, imem_addr, RST); end
      tick();
    end
    imem_req_ready = 1'b1;
    total++; if (imem_req_valid !== 1'b1) begin bad++; $display("FAIL stall_5th_valid got=%b exp=1", imem_req_valid); end
    tick();
    imem_req_ready = 1'b0;
    total++; if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0) begin bad++; $display("FAIL stall_wait got req=%b ivalid=%b exp 0/0", imem_req_valid, instr_valid); end
    $display("req_stall: request held 4 cycles then accepted at %h", imem_addr);
  endtask

  // Continues from WAIT at RST.
  task automatic test_hold();
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h00A0_0093;
    tick();
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (instr_valid !== 1'b1 || opcode !== 7'b0010011 || instr !== 32'h00A0_0093 || pc_out !== RST) begin
        bad++; $display("FAIL hold%0d got v=%b op=%b instr=%h pc=%h exp v=1 op=0010011 instr=00a00093 pc=%h", i, instr_valid, opcode, instr, pc_out, RST);
      end
      tick();
    end
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    total++;
    if (instr_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_addr !== RST + 32'd4 || retired_count !== 32'd1) begin
      bad++; $display("FAIL hold_advance got iv=%b rv=%b addr=%h ret=%0d exp iv=0 rv=1 addr=%h ret=1", instr_valid, imem_req_valid, imem_addr, retired_count, RST + 32'd4);
    end
    $display("hold: instr=%h accepted, next addr=%h", instr, imem_addr);
  endtask

  // Continues from REQ at RST+4.
  task automatic test_spurious();
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hFFFF_FFFF;
    tick();
    imem_rsp_valid = 1'b0;
    total++;
    if (instr !== 32'h00A0_0093 || imem_req_valid !== 1'b1 || imem_addr !== RST + 32'd4 || instr_valid !== 1'b0) begin
      bad++; $display("FAIL spurious got instr=%h rv=%b addr=%h iv=%b exp instr=00a00093 rv=1 addr=%h iv=0", instr, imem_req_valid, imem_addr, instr_valid, RST + 32'd4);
    end
    $display("spurious: instr=%h still requesting %h", instr, imem_addr);
  endtask

  // Continues from REQ at RST+4.
  task automatic test_branch();
    fetch_one(NOP, 1'b0, '0);
    branch_taken  = 1'b1;
    branch_target = 32'h0000_0400;
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h0000_0063;
    tick();
    imem_rsp_valid = 1'b0;
    total++;
    if (instr_valid !== 1'b1 || pc_out !== 32'h108 || opcode !== 7'b1100011) begin
      bad++; $display("FAIL branch_ignored got iv=%b pc=%h op=%b exp iv=1 pc=00000108 op=1100011", instr_valid, pc_out, opcode);
    end
    branch_target = 32'h0000_0203;
    instr_ready   = 1'b1;
    tick();
    instr_ready  = 1'b0;
    branch_taken = 1'b0;
    total++;
    if (imem_req_valid !== 1'b1 || imem_addr !== 32'h200) begin
      bad++; $display("FAIL branch_target got rv=%b addr=%h exp rv=1 addr=00000200", imem_req_valid, imem_addr);
    end
    $display("branch: redirect from 108 to %h", imem_addr);
  endtask

  task automatic test_wrap();
    fetch_one(NOP, 1'b1, 32'hFFFF_FFFF);
    total++; if (imem_addr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_top got=%h exp=fffffffc", imem_addr); end
    fetch_one(NOP, 1'b0, '0);
    total++; if (imem_addr !== 32'h0 || imem_req_valid !== 1'b1) begin bad++; $display("FAIL wrap_zero got rv=%b addr=%h exp rv=1 addr=00000000", imem_req_valid, imem_addr); end
    $display("wrap: fffffffc + 4 -> %h", imem_addr);
  endtask

  // Starts from REQ; resets asynchronously while WAIT.
  task automatic test_reset_mid();
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0 || pc_out !== RST || retired_count !== 32'd0 || instr !== NOP) begin
      bad++; $display("FAIL async_reset got rv=%b iv=%b pc=%h ret=%0d instr=%h exp 0/0/%h/0/%h", imem_req_valid, instr_valid, pc_out, retired_count, instr, RST, NOP);
    end
    tick();
    rst_n = 1'b1;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hDEAD_BEEF;
    tick();
    tick();
    imem_rsp_valid = 1'b0;
    total++;
    if (instr !== NOP || imem_req_valid !== 1'b1 || imem_addr !== RST) begin
      bad++; $display("FAIL late_rsp got instr=%h rv=%b addr=%h exp instr=%h rv=1 addr=%h", instr, imem_req_valid, imem_addr, NOP, RST);
    end
    $display("reset_mid: late response dropped, restart at %h", imem_addr);
  endtask

  task automatic test_random();
    logic [XL-1:0] m_pc;
    logic [31:0]   m_cnt;
    logic [31:0]   m_word;
    bit            outstanding;
    bit            have;
    bit            want_req;
    bit            had;
    int            delay;
    int            n_acc = 0;
    apply_reset();
    tick();
    m_pc = RST; m_cnt = 0; m_word = NOP; outstanding = 0; have = 0; delay = 0;
    for (int c = 0; c < 600; c++) begin
      want_req = !outstanding && !have;
      had = have;
      total++; if (imem_req_valid !== want_req) begin bad++; $display("FAIL rnd_req_valid c=%0d got=%b exp=%b", c, imem_req_valid, want_req); end
      total++; if (instr_valid !== have) begin bad++; $display("FAIL rnd_instr_valid c=%0d got=%b exp=%b", c, instr_valid, have); end
      total++; if (pc_out !== m_pc || imem_addr !== m_pc) begin bad++; $display("FAIL rnd_pc c=%0d got=%h/%h exp=%h", c, pc_out, imem_addr, m_pc); end
      total++; if (retired_count !== m_cnt) begin bad++; $display("FAIL rnd_retired c=%0d got=%0d exp=%0d", c, retired_count, m_cnt); end
      if (have) begin
        total++; if (instr !== m_word || opcode !== m_word[6:0]) begin bad++; $display("FAIL rnd_instr c=%0d got=%h op=%h exp=%h op=%h", c, instr, opcode, m_word, m_word[6:0]); end
      end
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
      if (outstanding) begin
        if (delay == 0) begin
          imem_rsp_valid = 1'b1;
          m_word = imem_rsp_data;
          outstanding = 0;
          have = 1;
        end else begin
          delay--;
        end
      end else if ($urandom_range(0, 3) == 0) begin
        imem_rsp_valid = 1'b1;
      end
      instr_ready    = ($urandom_range(0, 2) != 0);
      branch_taken   = ($urandom_range(0, 3) == 0);
      branch_target  = $urandom;
      imem_req_ready = ($urandom_range(0, 2) != 0);
      if (had && instr_ready) begin
        m_pc = branch_taken ? {branch_target[XL-1:2], 2'b00} : m_pc + 32'd4;
        m_cnt++;
        have = 0;
        n_acc++;
      end
      if (want_req && imem_req_ready) begin
        outstanding = 1;
        delay = $urandom_range(0, 3);
      end
      tick();
    end
    idle_inputs();
    $display("random: %0d instructions accepted, retired_count=%0d", n_acc, retired_count);
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    test_reset();
    test_throughput();
    test_req_stall();
    test_hold();
    test_spurious();
    test_branch();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
